// File: rtl/apb_master_bridge_if.sv
// Purpose: bundles the command/response handshake and the APB bus of the
//          APB master bridge.
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : command port
//   rsp_valid/rsp_rdata/rsp_err                      : response pulse
//   paddr/pwdata/pwrite/psel/penable/pready/prdata   : APB initiator bus
// Modports:
//   master : the bridge (accepts commands, drives APB)
//   slave  : the requester plus APB target environment around the bridge
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, pready, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               paddr, pwdata, pwrite, psel, penable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, pready, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Purpose: turns a single-outstanding request/response command port into APB
//          SETUP/ACCESS transfers, aborting with an error response if PREADY
//          stays low for TIMEOUT ACCESS cycles.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : apb_master_bridge_if.master (command, response and APB signals)
// Timing: accept edge -> SETUP cycle -> ACCESS cycle(s) -> one-cycle response
//         pulse, during which the bridge is already idle and can accept again.
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_master_bridge_if.master  bus
);

    // Counter only ever holds 0..TIMEOUT-1; the TIMEOUT-th low cycle aborts.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              pwrite_q,    pwrite_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              req_ready_c;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    paddr_d  = bus.req_addr;
                    pwdata_d = bus.req_wdata;
                    pwrite_d = bus.req_write;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Completion is checked first so PREADY on the expiring cycle wins.
                if (bus.pready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // APB strobes registered from the next state so they track it exactly.
        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
    end

    assign req_ready_c   = (state_q == ST_IDLE);

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;

endmodule
